rv_branch_predictor: RTL and testbench
======================================

Name: rv_branch_predictor

Overview:
- Fetch-stage dynamic branch predictor for the 5-stage RV32I pipeline.
- Combines a direct-mapped BTB (tag, target, valid, is_jump) with 2-bit saturating direction counters.
- Lookup is combinational in F. Training and mispredict detection happen in E.
- Replaces always-not-taken fetch: the pipeline flushes D/E only on `mispredict_e`, not on every taken branch/jump.

Parameters:
- XLEN, 32, data/PC width.
- ENTRIES, 16, BTB and counter-table depth; power of 2, ≥2.
- TAG_W, 8, stored tag bits per entry.
- IDX_W, $clog2(ENTRIES), derived; index = pc[IDX_W+1:2].

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, asynchronous, active-low reset (asserted when 0).
- pc_f, in, XLEN, fetch PC.
- pred_taken_f, out, 1, predict redirect.
- pred_target_f, out, XLEN, next PC: BTB target if pred_taken_f, else pc_f+4.
- pred_idx_f, out, IDX_W, counter index used; pipeline carries it to E.
- upd_valid_e, in, 1, E-stage instruction valid (not flushed).
- upd_branch_e, in, 1, instruction is a conditional branch.
- upd_jump_e, in, 1, instruction is jal/jalr.
- upd_taken_e, in, 1, resolved outcome (the pipeline's PCSrcE).
- upd_target_e, in, XLEN, resolved target (PCTargetE or jalr ALU result).
- upd_pc_e, in, XLEN, PC of the E instruction.
- upd_pred_taken_e, in, 1, pred_taken_f carried to E.
- upd_pred_target_e, in, XLEN, pred_target_f carried to E.
- upd_pred_idx_e, in, IDX_W, pred_idx_f carried to E.
- invalidate, in, 1, clear all BTB valid bits (fence.i).
- mispredict_e, out, 1, flush D/E and redirect.
- redirect_pc_e, out, XLEN, correct next PC.

Behaviour:
- Reset (async, reset=0):
  - All valid=0.
  - All counters=2'b01 (weakly not-taken).
  - GHR=0.
  - Outputs are combinational; with an empty table they give pred_taken_f=0, pred_target_f=pc_f+4.
- Lookup (F, combinational):
  - i = pc_f[IDX_W+1:2].
  - hit = valid[i] & (tag[i] == pc_f[IDX_W+TAG_W+1:IDX_W+2]).
  - pred_taken_f = hit & (is_jump[i] | ctr[pred_idx_f][1]).
  - pred_idx_f = i.
- Resolution (E, combinational):
  - act = upd_valid_e & (upd_branch_e | upd_jump_e).
  - mispredict_e = upd_valid_e & ((upd_taken_e != upd_pred_taken_e) | (upd_taken_e & upd_target_e != upd_pred_target_e)).
  - redirect_pc_e = upd_taken_e ? upd_target_e : upd_pc_e+4.
  - When upd_valid_e=0, mispredict_e=0.
  - A non-control instruction predicted taken (tag alias) is a mispredict and redirects to pc+4.
- Training (clock edge, when act=1):
  - Index j = upd_pc_e[IDX_W+1:2]; E-hit is the tag match at j.
  - E-hit: target[j] ← upd_target_e; is_jump[j] ← upd_jump_e.
  - E-miss and upd_taken_e: allocate/overwrite j with valid=1, tag, target, is_jump; counter[upd_pred_idx_e] ← 2'b10.
  - E-miss and not taken: no allocation, table unchanged.
  - Counter on hit: saturating increment if taken, decrement if not. Holds at 11 and 00; never wraps.
  - Jumps: counter forced to 11 on allocate; not touched on hit.
- Simultaneous events:
  - Same-cycle lookup and update to the same index: lookup returns pre-edge contents.
  - invalidate together with act: invalidate wins for valid bits, so the entry ends invalid. Counters still train.
  - Reset mid-operation: all state returns to reset values immediately.
- Non-control upd_valid_e with act=0: no state change.

Optional Feature:
- Macro: RV_BP_GSHARE_EN.
- Defined:
  - IDX_W-bit global history register GHR.
  - pred_idx_f = pc_f[IDX_W+1:2] ^ GHR.
  - On act & upd_branch_e: GHR ← {GHR[IDX_W-2:0], upd_taken_e}. Jumps do not shift.
  - On mispredict the GHR is not repaired; history is updated only at E.
  - Counter training uses upd_pred_idx_e. BTB indexing stays PC-only.
- Undefined:
  - No GHR; pred_idx_f = PC index.
  - Counters are indexed by upd_pred_idx_e (equal to the PC index).

Decomposition:
- Package rv_bp_pkg:
  - Counter typedef enum {SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11}.
  - Function sat_update(ctr, taken).
  - Constant CTR_RESET=WNT.
- One natural sub-module: rv_bp_btb_array, holding tag/target/valid/is_jump storage, async reset, with one combinational read port and one write port plus the bulk-invalidate input.

Test Plan:
- Reset then pc_f=0x40 → pred_taken_f=0, pred_target_f=0x44, mispredict_e=0.
- Taken beq at 0x40, target 0x80, predicted 0 → mispredict_e=1, redirect_pc_e=0x80.
  - Next cycle, pc_f=0x40 → pred_taken_f=1, pred_target_f=0x80.
- Same branch resolved not-taken 3 times → counter 10→01→00→00 (saturates).
  - Lookup gives pred_taken_f=0; the second resolution mispredicts with redirect_pc_e=0x44.
- jal at 0x100 → 0x200 allocates with ST.
  - Next lookup predicts 0x200.
  - Later resolution with target 0x200 and prediction 0x200 → mispredict_e=0.
- Alias: ENTRIES=16, entry at 0x40, then non-control instruction at 0x40+(16<<2)·2^TAG_W with matching tag → predicted taken.
  - Resolves mispredict_e=1, redirect_pc_e=pc+4.
- invalidate asserted with a simultaneous allocate → entry invalid, next lookup predicts pc+4.
- With RV_BP_GSHARE_EN defined, two taken branches → GHR=2'b…11, and pred_idx_f = pc index ^ 0x3.

Source files
------------

// File: rtl/rv_bp_pkg.sv
// Shared types and helpers for the RV32I fetch-stage branch predictor.
// Optional gshare indexing is selected in the top by RV_BP_GSHARE_EN.
package rv_bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = WNT;

    // Two-bit saturating counter step; holds at SNT and ST instead of wrapping.
    function automatic ctr_e sat_update(input ctr_e ctr, input logic taken);
        ctr_e res;
        case (ctr)
            SNT:     res = taken ? WNT : SNT;
            WNT:     res = taken ? WT  : SNT;
            WT:      res = taken ? ST  : WNT;
            default: res = taken ? ST  : WT;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rv_bp_btb_array.sv
// Direct-mapped BTB storage: tag/target/valid/is_jump with one lookup read port,
// a tag-match probe for the training side, one write port and bulk invalidate.
module rv_bp_btb_array
    import rv_bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [XLEN-1:0]  rd_target_o,
    output logic             rd_is_jump_o,
    input  logic [IDX_W-1:0] probe_idx_i,
    input  logic [TAG_W-1:0] probe_tag_i,
    output logic             probe_hit_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [XLEN-1:0]  wr_target_i,
    input  logic             wr_is_jump_i,
    input  logic             inval_i
);

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [ENTRIES-1:0] is_jump_q;

    assign rd_valid_o   = valid_q[rd_idx_i];
    assign rd_tag_o     = tag_q[rd_idx_i];
    assign rd_target_o  = target_q[rd_idx_i];
    assign rd_is_jump_o = is_jump_q[rd_idx_i];

    assign probe_hit_o = valid_q[probe_idx_i] & (tag_q[probe_idx_i] == probe_tag_i);

    // Invalidate beats a same-cycle write so a fence.i never leaves a fresh entry live.
    always_comb begin
        valid_d = valid_q;
        if (inval_i) begin
            valid_d = '0;
        end else if (wr_en_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q   <= '0;
            is_jump_q <= '0;
            for (int k = 0; k < ENTRIES; k++) begin
                tag_q[k]    <= '0;
                target_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            if (wr_en_i) begin
                tag_q[wr_idx_i]     <= wr_tag_i;
                target_q[wr_idx_i]  <= wr_target_i;
                is_jump_q[wr_idx_i] <= wr_is_jump_i;
            end
        end
    end

endmodule

// File: rtl/rv_branch_predictor.sv
// Fetch-stage dynamic branch predictor: direct-mapped BTB plus 2-bit direction counters,
// combinational lookup in F, resolution and training in E. RV_BP_GSHARE_EN enables gshare indexing.
module rv_branch_predictor
    import rv_bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [XLEN-1:0]  pc_f,
    output logic             pred_taken_f,
    output logic [XLEN-1:0]  pred_target_f,
    output logic [IDX_W-1:0] pred_idx_f,
    input  logic             upd_valid_e,
    input  logic             upd_branch_e,
    input  logic             upd_jump_e,
    input  logic             upd_taken_e,
    input  logic [XLEN-1:0]  upd_target_e,
    input  logic [XLEN-1:0]  upd_pc_e,
    input  logic             upd_pred_taken_e,
    input  logic [XLEN-1:0]  upd_pred_target_e,
    input  logic [IDX_W-1:0] upd_pred_idx_e,
    input  logic             invalidate,
    output logic             mispredict_e,
    output logic [XLEN-1:0]  redirect_pc_e
);

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [XLEN-1:0]  rd_target;
    logic             rd_is_jump;
    logic             f_hit;
    logic             e_hit;

    logic             act;
    logic             btb_we;
    ctr_e             ctr_q [ENTRIES];
    ctr_e             ctr_d;
    logic             ctr_we;
    logic [1:0]       f_ctr;

    assign f_idx = pc_f[IDX_W+1:2];
    assign f_tag = pc_f[IDX_W+TAG_W+1:IDX_W+2];
    assign e_idx = upd_pc_e[IDX_W+1:2];
    assign e_tag = upd_pc_e[IDX_W+TAG_W+1:IDX_W+2];

    rv_bp_btb_array #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk_i        (clock),
        .rst_ni       (reset),
        .rd_idx_i     (f_idx),
        .rd_valid_o   (rd_valid),
        .rd_tag_o     (rd_tag),
        .rd_target_o  (rd_target),
        .rd_is_jump_o (rd_is_jump),
        .probe_idx_i  (e_idx),
        .probe_tag_i  (e_tag),
        .probe_hit_o  (e_hit),
        .wr_en_i      (btb_we),
        .wr_idx_i     (e_idx),
        .wr_tag_i     (e_tag),
        .wr_target_i  (upd_target_e),
        .wr_is_jump_i (upd_jump_e),
        .inval_i      (invalidate)
    );

`ifdef RV_BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;
    logic [IDX_W-1:0] ghr_d;
    logic [IDX_W:0]   ghr_shift;

    // History advances only on resolved conditional branches; no repair on mispredict.
    always_comb begin
        ghr_shift = {ghr_q, upd_taken_e};
        ghr_d     = ghr_q;
        if (act && upd_branch_e) begin
            ghr_d = ghr_shift[IDX_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign pred_idx_f = f_idx ^ ghr_q;
`else
    assign pred_idx_f = f_idx;
`endif

    // Direction counters are read through pred_idx_f; the BTB stays PC-indexed.
    assign f_hit         = rd_valid & (rd_tag == f_tag);
    assign f_ctr         = ctr_q[pred_idx_f];
    assign pred_taken_f  = f_hit & (rd_is_jump | f_ctr[1]);
    assign pred_target_f = pred_taken_f ? rd_target : pc_f + XLEN'(4);

    always_comb begin
        act           = upd_valid_e & (upd_branch_e | upd_jump_e);
        mispredict_e  = upd_valid_e &
                        ((upd_taken_e != upd_pred_taken_e) |
                         (upd_taken_e & (upd_target_e != upd_pred_target_e)));
        redirect_pc_e = upd_taken_e ? upd_target_e : upd_pc_e + XLEN'(4);
        btb_we        = act & (e_hit | upd_taken_e);
    end

    // A hit trains branches only; a taken miss seeds the counter (jumps strongly taken).
    always_comb begin
        ctr_we = 1'b0;
        ctr_d  = ctr_q[upd_pred_idx_e];
        if (act) begin
            if (e_hit) begin
                if (!upd_jump_e) begin
                    ctr_we = 1'b1;
                    ctr_d  = sat_update(ctr_q[upd_pred_idx_e], upd_taken_e);
                end
            end else if (upd_taken_e) begin
                ctr_we = 1'b1;
                ctr_d  = upd_jump_e ? ST : WT;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < ENTRIES; k++) begin
                ctr_q[k] <= CTR_RESET;
            end
        end else if (ctr_we) begin
            ctr_q[upd_pred_idx_e] <= ctr_d;
        end
    end

endmodule

// File: tb/tb_rv_branch_predictor.sv
// Bench for rv_branch_predictor: directed scenarios from the predictor's rules plus
// randomized traffic compared against a table-level model.
module tb_rv_branch_predictor;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int TAG_W   = 8;
    localparam int IDX_W   = 4;

    logic             clock;
    logic             reset;
    logic [XLEN-1:0]  pc_f;
    logic             pred_taken_f;
    logic [XLEN-1:0]  pred_target_f;
    logic [IDX_W-1:0] pred_idx_f;
    logic             upd_valid_e;
    logic             upd_branch_e;
    logic             upd_jump_e;
    logic             upd_taken_e;
    logic [XLEN-1:0]  upd_target_e;
    logic [XLEN-1:0]  upd_pc_e;
    logic             upd_pred_taken_e;
    logic [XLEN-1:0]  upd_pred_target_e;
    logic [IDX_W-1:0] upd_pred_idx_e;
    logic             invalidate;
    logic             mispredict_e;
    logic [XLEN-1:0]  redirect_pc_e;

    int n_pass  = 0;
    int n_total = 0;
    logic [XLEN:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    rv_branch_predictor dut (
        .clock             (clock),
        .reset             (reset),
        .pc_f              (pc_f),
        .pred_taken_f      (pred_taken_f),
        .pred_target_f     (pred_target_f),
        .pred_idx_f        (pred_idx_f),
        .upd_valid_e       (upd_valid_e),
        .upd_branch_e      (upd_branch_e),
        .upd_jump_e        (upd_jump_e),
        .upd_taken_e       (upd_taken_e),
        .upd_target_e      (upd_target_e),
        .upd_pc_e          (upd_pc_e),
        .upd_pred_taken_e  (upd_pred_taken_e),
        .upd_pred_target_e (upd_pred_target_e),
        .upd_pred_idx_e    (upd_pred_idx_e),
        .invalidate        (invalidate),
        .mispredict_e      (mispredict_e),
        .redirect_pc_e     (redirect_pc_e)
    );

    // ---------------- reference model ----------------
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [XLEN-1:0] m_target [ENTRIES];
    bit          m_jump   [ENTRIES];
    int          m_ctr    [ENTRIES];
    int unsigned m_ghr;

    function automatic int unsigned m_idx_of(input logic [XLEN-1:0] pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    function automatic int unsigned m_tag_of(input logic [XLEN-1:0] pc);
        return (pc >> (2 + IDX_W)) % (1 << TAG_W);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < ENTRIES; k++) begin
            m_valid[k] = 0; m_tag[k] = 0; m_target[k] = '0; m_jump[k] = 0; m_ctr[k] = 1;
        end
        m_ghr = 0;
    endfunction

    task automatic model_lookup(input logic [XLEN-1:0] pc, output logic t,
                                output logic [XLEN-1:0] tgt, output logic [IDX_W-1:0] idx);
        int unsigned i;
        int unsigned ci;
        bit hit;
        i   = m_idx_of(pc);
        ci  = i;
`ifdef RV_BP_GSHARE_EN
        ci  = i ^ m_ghr;
`endif
        hit = m_valid[i] && (m_tag[i] == m_tag_of(pc));
        t   = hit && (m_jump[i] || m_ctr[ci] >= 2);
        tgt = t ? m_target[i] : pc + 4;
        idx = IDX_W'(ci);
    endtask

    // Applies one clock edge worth of training from the currently driven E-stage inputs.
    function automatic void model_train();
        int unsigned j;
        int unsigned p;
        bit act;
        bit hit;
        j   = m_idx_of(upd_pc_e);
        p   = int'(upd_pred_idx_e);
        act = upd_valid_e && (upd_branch_e || upd_jump_e);
        hit = m_valid[j] && (m_tag[j] == m_tag_of(upd_pc_e));
        if (act) begin
            if (hit) begin
                m_target[j] = upd_target_e;
                m_jump[j]   = upd_jump_e;
                if (!upd_jump_e) begin
                    if (upd_taken_e) m_ctr[p] = (m_ctr[p] < 3) ? m_ctr[p] + 1 : 3;
                    else             m_ctr[p] = (m_ctr[p] > 0) ? m_ctr[p] - 1 : 0;
                end
            end else if (upd_taken_e) begin
                m_valid[j]  = 1;
                m_tag[j]    = m_tag_of(upd_pc_e);
                m_target[j] = upd_target_e;
                m_jump[j]   = upd_jump_e;
                m_ctr[p]    = upd_jump_e ? 3 : 2;
            end
            if (upd_branch_e) m_ghr = ((m_ghr << 1) | int'(upd_taken_e)) % ENTRIES;
        end
        if (invalidate) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        upd_valid_e = 0; upd_branch_e = 0; upd_jump_e = 0; upd_taken_e = 0;
        upd_target_e = '0; upd_pc_e = '0; upd_pred_taken_e = 0;
        upd_pred_target_e = '0; upd_pred_idx_e = '0; invalidate = 0;
    endtask

    task automatic drive_upd(input logic [XLEN-1:0] pc, input logic br, input logic jp,
                             input logic tk, input logic [XLEN-1:0] tgt, input logic ptk,
                             input logic [XLEN-1:0] ptgt, input logic [IDX_W-1:0] pidx);
        upd_valid_e = 1; upd_branch_e = br; upd_jump_e = jp; upd_taken_e = tk;
        upd_target_e = tgt; upd_pc_e = pc; upd_pred_taken_e = ptk;
        upd_pred_target_e = ptgt; upd_pred_idx_e = pidx; invalidate = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_train();
    endtask

    task automatic apply_reset();
        reset = 0;
        drive_idle();
        @(posedge clock);
        #1;
        reset = 1;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 0;
        drive_idle();
        pc_f = 32'h40;
        @(posedge clock);
        #1;
        n_total++; if (pred_taken_f !== 1'b0) $display("FAIL reset_taken: got %0b want 0", pred_taken_f); else n_pass++;
        n_total++; if (pred_target_f !== 32'h44) $display("FAIL reset_target: got %h want 00000044", pred_target_f); else n_pass++;
        n_total++; if (mispredict_e !== 1'b0) $display("FAIL reset_mispredict: got %0b want 0", mispredict_e); else n_pass++;
        n_total++; if (redirect_pc_e !== 32'h4) $display("FAIL reset_redirect: got %h want 00000004", redirect_pc_e); else n_pass++;
        reset = 1;
        model_reset();
        #1;
        n_total++; if (pred_idx_f !== 4'h0) $display("FAIL reset_idx: got %h want 0", pred_idx_f); else n_pass++;
    endtask

    task automatic test_taken_branch();
        apply_reset();
        pc_f = 32'h40;
        drive_upd(32'h40, 1, 0, 1, 32'h80, 0, 32'h44, 4'h0);
        #1;
        n_total++; if (mispredict_e !== 1'b1) $display("FAIL beq_mispredict: got %0b want 1", mispredict_e); else n_pass++;
        n_total++; if (redirect_pc_e !== 32'h80) $display("FAIL beq_redirect: got %h want 00000080", redirect_pc_e); else n_pass++;
        n_total++; if (pred_taken_f !== 1'b0) $display("FAIL beq_pre_edge_lookup: got %0b want 0", pred_taken_f); else n_pass++;
        tick();
        drive_idle();
        #1;
        n_total++; if (pred_taken_f !== 1'b1) $display("FAIL beq_next_taken: got %0b want 1", pred_taken_f); else n_pass++;
        n_total++; if (pred_target_f !== 32'h80) $display("FAIL beq_next_target: got %h want 00000080", pred_target_f); else n_pass++;
    endtask

    task automatic test_saturation();
        apply_reset();
        pc_f = 32'h40;
        drive_upd(32'h40, 1, 0, 1, 32'h80, 0, 32'h44, 4'h0);
        tick();
        // Two in-flight copies predicted taken, then a freshly predicted not-taken one.
        for (int r = 0; r < 2; r++) begin
            drive_upd(32'h40, 1, 0, 0, 32'h80, 1, 32'h80, 4'h0);
            #1;
            n_total++; if (mispredict_e !== 1'b1) $display("FAIL sat_mis_%0d: got %0b want 1", r, mispredict_e); else n_pass++;
            n_total++; if (redirect_pc_e !== 32'h44) $display("FAIL sat_redirect_%0d: got %h want 00000044", r, redirect_pc_e); else n_pass++;
            tick();
        end
        drive_upd(32'h40, 1, 0, 0, 32'h80, 0, 32'h44, 4'h0);
        #1;
        n_total++; if (mispredict_e !== 1'b0) $display("FAIL sat_third_mis: got %0b want 0", mispredict_e); else n_pass++;
        tick();
        drive_idle();
        #1;
        n_total++; if (pred_taken_f !== 1'b0) $display("FAIL sat_floor_taken: got %0b want 0", pred_taken_f); else n_pass++;
        n_total++; if (pred_target_f !== 32'h44) $display("FAIL sat_floor_target: got %h want 00000044", pred_target_f); else n_pass++;
        // From the floor, one taken step must still predict not-taken; a second flips it.
        drive_upd(32'h40, 1, 0, 1, 32'h80, 0, 32'h44, 4'h0);
        tick();
        drive_idle();
        #1;
        n_total++; if (pred_taken_f !== 1'b0) $display("FAIL sat_up1_taken: got %0b want 0", pred_taken_f); else n_pass++;
        drive_upd(32'h40, 1, 0, 1, 32'h80, 0, 32'h44, 4'h0);
        tick();
        drive_idle();
        #1;
        n_total++; if (pred_taken_f !== 1'b1) $display("FAIL sat_up2_taken: got %0b want 1", pred_taken_f); else n_pass++;
    endtask

    task automatic test_jump();
        apply_reset();
        pc_f = 32'h100;
        drive_upd(32'h100, 0, 1, 1, 32'h200, 0, 32'h104, 4'h0);
        #1;
        n_total++; if (redirect_pc_e !== 32'h200) $display("FAIL jal_redirect: got %h want 00000200", redirect_pc_e); else n_pass++;
        tick();
        drive_idle();
        #1;
        n_total++; if (pred_taken_f !== 1'b1) $display("FAIL jal_taken: got %0b want 1", pred_taken_f); else n_pass++;
        n_total++; if (pred_target_f !== 32'h200) $display("FAIL jal_target: got %h want 00000200", pred_target_f); else n_pass++;
        drive_upd(32'h100, 0, 1, 1, 32'h200, 1, 32'h200, 4'h0);
        #1;
        n_total++; if (mispredict_e !== 1'b0) $display("FAIL jal_correct_mis: got %0b want 0", mispredict_e); else n_pass++;
        tick();
        drive_upd(32'h100, 0, 1, 1, 32'h300, 1, 32'h200, 4'h0);
        #1;
        n_total++; if (mispredict_e !== 1'b1) $display("FAIL jalr_target_mis: got %0b want 1", mispredict_e); else n_pass++;
        n_total++; if (redirect_pc_e !== 32'h300) $display("FAIL jalr_redirect: got %h want 00000300", redirect_pc_e); else n_pass++;
        tick();
        // A not-taken branch hit decrements the jump-seeded counter from ST to WT: still taken.
        drive_upd(32'h100, 1, 0, 0, 32'h300, 1, 32'h300, 4'h0);
        #1;
        n_total++; if (redirect_pc_e !== 32'h104) $display("FAIL jal_ctr_redirect: got %h want 00000104", redirect_pc_e); else n_pass++;
        tick();
        drive_idle();
        #1;
        n_total++; if (pred_taken_f !== 1'b1) $display("FAIL jal_ctr_st: got %0b want 1", pred_taken_f); else n_pass++;
        n_total++; if (pred_target_f !== 32'h300) $display("FAIL jal_ctr_target: got %h want 00000300", pred_target_f); else n_pass++;
    endtask

    task automatic test_alias();
        apply_reset();
        pc_f = 32'h40;
        drive_upd(32'h40, 1, 0, 1, 32'h80, 0, 32'h44, 4'h0);
        tick();
        drive_idle();
        pc_f = 32'h4040;
        #1;
        n_total++; if (pred_taken_f !== 1'b1) $display("FAIL alias_taken: got %0b want 1", pred_taken_f); else n_pass++;
        drive_upd(32'h4040, 0, 0, 0, 32'h0, 1, 32'h80, 4'h0);
        #1;
        n_total++; if (mispredict_e !== 1'b1) $display("FAIL alias_mis: got %0b want 1", mispredict_e); else n_pass++;
        n_total++; if (redirect_pc_e !== 32'h4044) $display("FAIL alias_redirect: got %h want 00004044", redirect_pc_e); else n_pass++;
        tick();
        drive_idle();
        pc_f = 32'h40;
        #1;
        n_total++; if (pred_target_f !== 32'h80) $display("FAIL alias_no_change: got %h want 00000080", pred_target_f); else n_pass++;
    endtask

    task automatic test_invalidate();
        apply_reset();
        pc_f = 32'h40;
        drive_upd(32'h40, 1, 0, 1, 32'h80, 0, 32'h44, 4'h0);
        invalidate = 1;
        tick();
        drive_idle();
        #1;
        n_total++; if (pred_taken_f !== 1'b0) $display("FAIL inval_alloc_taken: got %0b want 0", pred_taken_f); else n_pass++;
        n_total++; if (pred_target_f !== 32'h44) $display("FAIL inval_alloc_target: got %h want 00000044", pred_target_f); else n_pass++;
        drive_upd(32'h40, 1, 0, 1, 32'h80, 0, 32'h44, 4'h0);
        tick();
        drive_idle();
        invalidate = 1;
        tick();
        invalidate = 0;
        #1;
        n_total++; if (pred_taken_f !== 1'b0) $display("FAIL inval_live_taken: got %0b want 0", pred_taken_f); else n_pass++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        pc_f = 32'h40;
        drive_upd(32'h40, 1, 0, 1, 32'h80, 0, 32'h44, 4'h0);
        tick();
        drive_idle();
        #2;
        reset = 0;
        #1;
        n_total++; if (pred_taken_f !== 1'b0) $display("FAIL midreset_taken: got %0b want 0", pred_taken_f); else n_pass++;
        n_total++; if (pred_target_f !== 32'h44) $display("FAIL midreset_target: got %h want 00000044", pred_target_f); else n_pass++;
        @(posedge clock);
        #1;
        reset = 1;
        model_reset();
    endtask

`ifdef RV_BP_GSHARE_EN
    task automatic test_gshare();
        apply_reset();
        pc_f = 32'h40;
        for (int r = 0; r < 2; r++) begin
            drive_upd(32'h40, 1, 0, 1, 32'h80, 0, 32'h44, pred_idx_f);
            tick();
        end
        drive_idle();
        #1;
        n_total++; if (pred_idx_f !== 4'h3) $display("FAIL gshare_idx: got %h want 3", pred_idx_f); else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic t;
        logic [XLEN-1:0] tg;
        logic [IDX_W-1:0] ix;
        logic [XLEN-1:0] upc;
        logic [XLEN-1:0] utg;
        logic ptk;
        logic [XLEN-1:0] ptg;
        logic [IDX_W-1:0] pix;
        logic exp_mis;
        logic [XLEN:0] exp_v;
        int kind;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            pc_f = XLEN'($urandom_range(0, 63)) << 2;
            upc  = XLEN'($urandom_range(0, 63)) << 2;
            utg  = XLEN'($urandom_range(0, 255)) << 2;
            kind = int'($urandom_range(0, 3));
            model_lookup(upc, ptk, ptg, pix);
            if ($urandom_range(0, 3) == 0) begin
                ptk = ~ptk;
                ptg = ptk ? (XLEN'($urandom_range(0, 255)) << 2) : upc + 4;
            end
            if (ptk && $urandom_range(0, 1) == 1) utg = ptg;
            upd_valid_e       = ($urandom_range(0, 3) != 0);
            upd_branch_e      = (kind == 1 || kind == 2);
            upd_jump_e        = (kind == 3);
            upd_taken_e       = (kind == 3) ? 1'b1 : (upd_branch_e ? 1'($urandom_range(0, 1)) : 1'b0);
            upd_target_e      = utg;
            upd_pc_e          = upc;
            upd_pred_taken_e  = ptk;
            upd_pred_target_e = ptg;
            upd_pred_idx_e    = pix;
            invalidate        = ($urandom_range(0, 31) == 0);
            #1;
            model_lookup(pc_f, t, tg, ix);
            n_total++; if (pred_taken_f !== t) $display("FAIL rnd_taken c=%0d pc=%h: got %0b want %0b", c, pc_f, pred_taken_f, t); else n_pass++;
            n_total++; if (pred_target_f !== tg) $display("FAIL rnd_target c=%0d pc=%h: got %h want %h", c, pc_f, pred_target_f, tg); else n_pass++;
            n_total++; if (pred_idx_f !== ix) $display("FAIL rnd_idx c=%0d pc=%h: got %h want %h", c, pc_f, pred_idx_f, ix); else n_pass++;
            exp_mis = upd_valid_e && ((upd_taken_e != ptk) || (upd_taken_e && utg != ptg));
            exp_q.push_back({exp_mis, upd_taken_e ? utg : upc + 4});
            exp_v = exp_q.pop_front();
            n_total++; if ({mispredict_e, redirect_pc_e} !== exp_v) $display("FAIL rnd_resolve c=%0d: got %0b/%h want %0b/%h", c, mispredict_e, redirect_pc_e, exp_v[XLEN], exp_v[XLEN-1:0]); else n_pass++;
            tick();
        end
        drive_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 0;
        pc_f  = '0;
        drive_idle();
        model_reset();
        test_reset();
        test_taken_branch();
        test_saturation();
        test_jump();
        test_alias();
        test_invalidate();
        test_reset_mid();
`ifdef RV_BP_GSHARE_EN
        test_gshare();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
